// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: detects an interrupt, exception or mret at
// commit, drains the pipeline, then issues a single-cycle CSR update and a fetch redirect.
module trap_ctrl #(
    parameter int unsigned MXLEN         = 64,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             commit_valid_i,
    input  logic [MXLEN-1:0] commit_pc_i,
    input  logic             commit_exc_i,
    input  logic [MXLEN-2:0] commit_cause_i,
    input  logic [MXLEN-1:0] commit_tval_i,
    input  logic             commit_mret_i,
    input  logic [1:0]       priv_i,
    input  logic             mstatus_mie_i,
    input  logic [MXLEN-1:0] mie_i,
    input  logic [MXLEN-1:0] mip_i,
    input  logic [MXLEN-1:0] mtvec_i,
    input  logic [MXLEN-1:0] mepc_i,
    input  logic             pipe_empty_i,
    output logic             retire_o,
    output logic             stall_commit_o,
    output logic             flush_o,
    output logic             trap_we_o,
    output logic [MXLEN-1:0] trap_mcause_o,
    output logic [MXLEN-1:0] trap_mepc_o,
    output logic [MXLEN-1:0] trap_mtval_o,
    output logic             trap_mret_o,
    output logic             redirect_valid_o,
    output logic [MXLEN-1:0] redirect_pc_o,
    output logic             hang_o
);

    localparam int unsigned CNT_W        = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [1:0]  MACHINE_MODE = 2'b11;
    // Machine external (11), software (3) and timer (7) interrupt bits.
    localparam logic [MXLEN-1:0] IRQ_MASK = MXLEN'(12'h888);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_UPDATE
    } state_e;

    typedef enum logic [1:0] {
        K_IRQ,
        K_EXC,
        K_MRET
    } kind_e;

    state_e           state_q;
    kind_e            kind_q, kind_d;
    logic [MXLEN-1:0] cause_q, cause_d;
    logic [MXLEN-1:0] epc_q;
    logic [MXLEN-1:0] tval_q, tval_d;
    logic [MXLEN-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_q, flush_q, trap_we_q, trap_mret_q, redir_q, hang_q;

    logic [MXLEN-1:0] pend;
    logic             irq_elig;
    logic [3:0]       irq_code;
    logic [MXLEN-1:0] vec_base;
    logic             event_c;

    // Interrupt eligibility, fixed priority encode and trap target selection.
    always_comb begin
        pend     = mie_i & mip_i & IRQ_MASK;
        irq_elig = ((priv_i != MACHINE_MODE) | mstatus_mie_i) & (|pend);
        if (pend[11])     irq_code = 4'd11;
        else if (pend[3]) irq_code = 4'd3;
        else              irq_code = 4'd7;

        vec_base = mtvec_i & ~MXLEN'(3);
        event_c  = (state_q == S_IDLE) & commit_valid_i
                   & (irq_elig | commit_exc_i | commit_mret_i);
        retire_o = (state_q == S_IDLE) & commit_valid_i & ~event_c;

        kind_d   = K_MRET;
        cause_d  = '0;
        tval_d   = '0;
        target_d = mepc_i;
        if (irq_elig) begin
            kind_d   = K_IRQ;
            cause_d  = {1'b1, (MXLEN-1)'(irq_code)};
            target_d = (mtvec_i[1:0] == 2'b01) ? vec_base + MXLEN'({irq_code, 2'b00})
                                               : vec_base;
        end else if (commit_exc_i) begin
            kind_d   = K_EXC;
            cause_d  = {1'b0, commit_cause_i};
            tval_d   = commit_tval_i;
            target_d = vec_base;
        end

        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Sequencer: capture on event, drain until empty, one-cycle CSR update + redirect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            kind_q      <= K_IRQ;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            trap_we_q   <= 1'b0;
            trap_mret_q <= 1'b0;
            redir_q     <= 1'b0;
            hang_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (event_c) begin
                        state_q  <= S_DRAIN;
                        kind_q   <= kind_d;
                        cause_q  <= cause_d;
                        epc_q    <= commit_pc_i;
                        tval_q   <= tval_d;
                        target_q <= target_d;
                        cnt_q    <= '0;
                        stall_q  <= 1'b1;
                        flush_q  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == CNT_MAX) hang_q <= 1'b1;
                    if (pipe_empty_i) begin
                        state_q     <= S_UPDATE;
                        flush_q     <= 1'b0;
                        trap_we_q   <= (kind_q != K_MRET);
                        trap_mret_q <= (kind_q == K_MRET);
                        redir_q     <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    stall_q     <= 1'b0;
                    trap_we_q   <= 1'b0;
                    trap_mret_q <= 1'b0;
                    redir_q     <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_commit_o   = stall_q;
    assign flush_o          = flush_q;
    assign trap_we_o        = trap_we_q;
    assign trap_mret_o      = trap_mret_q;
    assign redirect_valid_o = redir_q;
    assign redirect_pc_o    = target_q;
    assign trap_mcause_o    = cause_q;
    assign trap_mepc_o      = epc_q;
    assign trap_mtval_o     = tval_q;
    assign hang_o           = hang_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: table of commit scenarios with a scoreboard of expected
// CSR updates, plus hand sequences for drain timeout and reset mid-drain.
module tb_trap_ctrl;

    localparam logic [1:0] PM = 2'b11;
    localparam logic [1:0] PS = 2'b01;
    localparam logic [1:0] PU = 2'b00;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [63:0] Z = 64'h0;
    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        resetn;
    logic        commit_valid_i, commit_exc_i, commit_mret_i, mstatus_mie_i, pipe_empty_i;
    logic [63:0] commit_pc_i, commit_tval_i, mie_i, mip_i, mtvec_i, mepc_i;
    logic [62:0] commit_cause_i;
    logic [1:0]  priv_i;
    logic        retire_o, stall_commit_o, flush_o, trap_we_o, trap_mret_o;
    logic        redirect_valid_o, hang_o;
    logic [63:0] trap_mcause_o, trap_mepc_o, trap_mtval_o, redirect_pc_o;

    typedef struct {
        logic valid; logic [1:0] priv; logic msie;
        logic [63:0] mie, mip, mtvec, mepc, pc;
        logic exc; logic [62:0] cause; logic [63:0] tval; logic mret; int drain;
        logic ev; logic retire; logic we; logic mr; logic chk_data;
        logic [63:0] mcause, mepc_o, mtval, target;
    } vec_t;

    typedef struct {
        logic we; logic mr; logic chk_data;
        logic [63:0] mcause, mepc, mtval, target;
        int drain;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    trap_ctrl #(.MXLEN(64), .DRAIN_TIMEOUT(255)) dut (
        .clk(clk), .resetn(resetn),
        .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
        .commit_exc_i(commit_exc_i), .commit_cause_i(commit_cause_i),
        .commit_tval_i(commit_tval_i), .commit_mret_i(commit_mret_i),
        .priv_i(priv_i), .mstatus_mie_i(mstatus_mie_i),
        .mie_i(mie_i), .mip_i(mip_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .pipe_empty_i(pipe_empty_i),
        .retire_o(retire_o), .stall_commit_o(stall_commit_o), .flush_o(flush_o),
        .trap_we_o(trap_we_o), .trap_mcause_o(trap_mcause_o),
        .trap_mepc_o(trap_mepc_o), .trap_mtval_o(trap_mtval_o),
        .trap_mret_o(trap_mret_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .hang_o(hang_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        commit_valid_i = 1'b0; commit_exc_i = 1'b0; commit_mret_i = 1'b0;
        commit_pc_i = '0; commit_tval_i = '0; commit_cause_i = '0;
        priv_i = PM; mstatus_mie_i = 1'b0; mie_i = '0; mip_i = '0;
        mtvec_i = '0; mepc_i = '0; pipe_empty_i = 1'b1;
    endtask

    // Apply one commit record, then follow the drain until the redirect (bounded).
    task automatic run_vec(input vec_t v, input int idx, input logic exp_hang);
        exp_t  e;
        int    flushes;
        int    lat;
        logic  seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        commit_valid_i = v.valid; priv_i = v.priv; mstatus_mie_i = v.msie;
        mie_i = v.mie; mip_i = v.mip; mtvec_i = v.mtvec; mepc_i = v.mepc;
        commit_pc_i = v.pc; commit_exc_i = v.exc; commit_cause_i = v.cause;
        commit_tval_i = v.tval; commit_mret_i = v.mret; pipe_empty_i = ~v.ev;
        #1 chk({tag, " retire"}, 64'(retire_o), 64'(v.retire));
        if (v.ev) begin
            e.we = v.we; e.mr = v.mr; e.chk_data = v.chk_data;
            e.mcause = v.mcause; e.mepc = v.mepc_o; e.mtval = v.mtval;
            e.target = v.target; e.drain = v.drain;
            sb.push_back(e);
        end
        flushes = 0; lat = 0; seen = 1'b0;
        for (int k = 1; k <= v.drain + 8 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // CSR inputs change after capture; the trap must not follow them.
                commit_valid_i = 1'b0; commit_exc_i = 1'b0; commit_mret_i = 1'b0;
                mie_i = '1; mip_i = '1; mtvec_i = '0; mepc_i = '0;
            end
            if (redirect_valid_o) begin
                seen = 1'b1;
                lat  = k;
                if (sb.size() == 0) begin
                    chk({tag, " unexpected redirect"}, 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk({tag, " trap_we"},    64'(trap_we_o),   64'(e.we));
                    chk({tag, " trap_mret"},  64'(trap_mret_o), 64'(e.mr));
                    chk({tag, " target"},     redirect_pc_o,    e.target);
                    chk({tag, " stall/flush"}, 64'({stall_commit_o, flush_o}), 64'(2'b10));
                    chk({tag, " hang"},       64'(hang_o),      64'(exp_hang));
                    chk({tag, " latency"},    64'(lat),         64'(e.drain + 1));
                    if (e.chk_data) begin
                        chk({tag, " mcause"}, trap_mcause_o, e.mcause);
                        chk({tag, " mepc"},   trap_mepc_o,   e.mepc);
                        chk({tag, " mtval"},  trap_mtval_o,  e.mtval);
                    end
                end
            end else if (flush_o) begin
                flushes++;
            end
            pipe_empty_i = (k >= v.drain);
        end
        chk({tag, " redirect seen"}, 64'(seen), 64'(v.ev));
        chk({tag, " flush cycles"}, 64'(flushes), 64'(v.ev ? v.drain : 0));
        if (seen) begin
            @(negedge clk);
            chk({tag, " pulse end"},
                64'({trap_we_o, trap_mret_o, redirect_valid_o, stall_commit_o}), 64'(0));
            if (v.chk_data) chk({tag, " mcause held"}, trap_mcause_o, v.mcause);
        end
        idle_inputs();
    endtask

    // Pipeline never drains for 300 cycles: sticky hang, then completion on empty.
    task automatic hang_seq();
        @(negedge clk);
        commit_valid_i = 1'b1; commit_exc_i = 1'b1; commit_cause_i = 63'd2;
        commit_pc_i = 64'h8000_0C00; mtvec_i = 64'h8000_1000; pipe_empty_i = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin commit_valid_i = 1'b0; commit_exc_i = 1'b0; end
            if (k == 200) chk("hang early", 64'(hang_o), 64'(0));
            if (k == 260) chk("hang set", 64'(hang_o), 64'(1));
            if (k == 300) chk("hang still draining", 64'({hang_o, flush_o}), 64'(2'b11));
            pipe_empty_i = (k == 300);
        end
        @(negedge clk);
        chk("hang completion", 64'({redirect_valid_o, trap_we_o, hang_o}), 64'(3'b111));
        chk("hang target", redirect_pc_o, 64'h8000_1000);
        idle_inputs();
    endtask

    // Reset asserted in the middle of a drain clears everything; no late CSR write.
    task automatic reset_mid_drain();
        int wr;
        @(negedge clk);
        commit_valid_i = 1'b1; commit_exc_i = 1'b1; commit_cause_i = 63'd2;
        commit_pc_i = 64'h8000_0D00; commit_tval_i = 64'h77;
        mtvec_i = 64'h8000_1000; pipe_empty_i = 1'b0;
        @(negedge clk);
        commit_valid_i = 1'b0; commit_exc_i = 1'b0;
        chk("rst pre flush", 64'(flush_o), 64'(1));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst ctrl outs", 64'({retire_o, stall_commit_o, flush_o, trap_we_o,
                                  trap_mret_o, redirect_valid_o, hang_o}), 64'(0));
        chk("rst data outs", trap_mcause_o | trap_mepc_o | trap_mtval_o | redirect_pc_o, Z);
        @(negedge clk);
        resetn = 1'b1; pipe_empty_i = 1'b1;
        wr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (trap_we_o || redirect_valid_o || trap_mret_o) wr++;
        end
        chk("rst no late write", 64'(wr), 64'(0));
        idle_inputs();
    endtask

    initial begin
        //          valid prv msie mie        mip        mtvec             mepc              pc                exc cause   tval          mret drn ev retire we mr data mcause                      mepc_o            mtval        target
        vecs[0]  = '{Y, PM, N, Z,         Z,         64'h8000_1000, Z,             64'h8000_0010, Y, 63'd2,  64'hdead, N, 3, Y, N, Y, N, Y, 64'h2,                      64'h8000_0010, 64'hdead, 64'h8000_1000};
        vecs[1]  = '{Y, PM, Y, 64'h888,   64'h888,   64'h8000_1001, Z,             64'h8000_0100, Y, 63'd11, Z,        N, 1, Y, N, Y, N, Y, 64'h8000_0000_0000_000B, 64'h8000_0100, Z,        64'h8000_102C};
        vecs[2]  = '{Y, PM, N, 64'h80,    64'h80,    64'h8000_1001, Z,             64'h8000_0200, N, 63'd0,  Z,        N, 1, N, Y, N, N, N, Z,                          Z,             Z,        Z};
        vecs[3]  = '{Y, PU, N, 64'h80,    64'h80,    64'h8000_1001, Z,             64'h8000_0300, N, 63'd0,  64'h55,   N, 2, Y, N, Y, N, Y, 64'h8000_0000_0000_0007, 64'h8000_0300, Z,        64'h8000_101C};
        vecs[4]  = '{Y, PM, N, Z,         Z,         64'h8000_1000, 64'h8000_0200, 64'h8000_0400, N, 63'd0,  Z,        Y, 1, Y, N, N, Y, N, Z,                          Z,             Z,        64'h8000_0200};
        vecs[5]  = '{Y, PM, Y, 64'h8,     64'h8,     64'h8000_2002, Z,             64'h8000_0500, N, 63'd0,  Z,        N, 2, Y, N, Y, N, Y, 64'h8000_0000_0000_0003, 64'h8000_0500, Z,        64'h8000_2000};
        vecs[6]  = '{Y, PU, N, Z,         64'h888,   64'h8000_3001, Z,             64'h8000_0600, Y, 63'd5,  64'h1234, N, 4, Y, N, Y, N, Y, 64'h5,                      64'h8000_0600, 64'h1234, 64'h8000_3000};
        vecs[7]  = '{Y, PM, Y, 64'h88,    64'hFFF,   64'h8000_1001, 64'h8000_0700, 64'h8000_0700, N, 63'd0,  Z,        Y, 1, Y, N, Y, N, Y, 64'h8000_0000_0000_0003, 64'h8000_0700, Z,        64'h8000_100C};
        vecs[8]  = '{Y, PM, Y, Z,         64'h888,   64'h8000_1001, Z,             64'h8000_0800, N, 63'd0,  Z,        N, 1, N, Y, N, N, N, Z,                          Z,             Z,        Z};
        vecs[9]  = '{N, PM, N, Z,         Z,         64'h8000_1000, Z,             64'h8000_0900, Y, 63'd2,  Z,        N, 1, N, N, N, N, N, Z,                          Z,             Z,        Z};
        vecs[10] = '{Y, PS, N, 64'hFFF,   64'h880,   64'h8000_4001, Z,             64'h8000_0A00, Y, 63'd2,  64'hbeef, N, 2, Y, N, Y, N, Y, 64'h8000_0000_0000_000B, 64'h8000_0A00, Z,        64'h8000_402C};

        idle_inputs();
        resetn = 1'b0;
        #12;
        chk("reset ctrl outs", 64'({retire_o, stall_commit_o, flush_o, trap_we_o,
                                    trap_mret_o, redirect_valid_o, hang_o}), 64'(0));
        chk("reset data outs", trap_mcause_o | trap_mepc_o | trap_mtval_o | redirect_pc_o, Z);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i, 1'b0);

        hang_seq();
        run_vec(vecs[0], 100, 1'b1);
        reset_mid_drain();
        chk("hang cleared by reset", 64'(hang_o), 64'(0));
        run_vec(vecs[1], 101, 1'b0);
        chk("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
